// File: rtl/softmax_pkg.sv
// Shared fixed-point definitions for the softmax datapath blocks.
//   Q_W / Q_FRAC       : default signed Q-format word and fraction widths
//   CORR_SH_A / _B     : shifts of the two-term mantissa correction (p/4 + p/16)
//   sat_val(w)         : largest positive value of a signed w-bit word
package softmax_pkg;

  localparam int Q_W       = 16;
  localparam int Q_FRAC    = 12;

  localparam int CORR_SH_A = 2;
  localparam int CORR_SH_B = 4;

  function automatic int sat_val(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/pow2_lane.sv
// One lane of the 2^x approximation, purely combinational.
//   S1 half: x, mode        -> ipart (floor of x), mant (1.f mantissa, optionally
//                              corrected by (p>>2)+(p>>4), p = f*(1-f))
//   S2 half: ipart_q,mant_q -> pow2 (mant scaled by 2^ipart, saturated), sat
// The two halves are independent; the parent registers between them.
module pow2_lane
  import softmax_pkg::*;
#(
  parameter int W    = Q_W,
  parameter int FRAC = Q_FRAC,
  localparam int IW  = W - FRAC,
  localparam int MW  = FRAC + 1
) (
  input  logic                 [W-1:0]  x,
  input  logic                          mode,
  output logic signed          [IW-1:0] ipart,
  output logic                 [MW-1:0] mant,
  input  logic signed          [IW-1:0] ipart_q,
  input  logic                 [MW-1:0] mant_q,
  output logic                 [W-1:0]  pow2,
  output logic                          sat
);

  localparam logic [MW-1:0] ONE   = {1'b1, {FRAC{1'b0}}};
  localparam int            SAT_I = W - 1 - FRAC;
  localparam int            PW    = 2 * FRAC + 1;

  logic [FRAC-1:0] f;
  logic [MW-1:0]   one_minus_f;
  logic [PW-1:0]   f_ext, omf_ext;
  logic [MW-1:0]   p, corr;
  int              sh;

  // S1: decompose and build the mantissa
  always_comb begin
    f           = x[FRAC-1:0];
    ipart       = x[W-1:FRAC];
    one_minus_f = ONE - {1'b0, f};
    f_ext       = {{(FRAC+1){1'b0}}, f};
    omf_ext     = {{FRAC{1'b0}}, one_minus_f};
    // f*(1-f) peaks at 1/4, so the shifted product always fits MW bits
    p           = MW'((f_ext * omf_ext) >> FRAC);
    corr        = (p >> CORR_SH_A) + (p >> CORR_SH_B);
    // corr < f whenever f > 0, so the corrected mantissa never drops below 1.0
    mant        = ONE + {1'b0, f} - (mode ? corr : '0);
  end

  // S2: scale by 2^ipart. Below SAT_I the left shift cannot reach the sign bit.
  always_comb begin
    pow2 = '0;
    sat  = 1'b0;
    sh   = int'(ipart_q);
    if (sh >= SAT_I) begin
      pow2 = W'(sat_val(W));
      sat  = 1'b1;
    end else if (sh >= 0) begin
      pow2 = W'(mant_q) << sh;
    end else if (-sh <= FRAC) begin
      pow2 = W'(mant_q) >> (-sh);
    end
  end

endmodule

// File: rtl/pow2_approx_vec.sv
// Vector 2^x approximation, LANES lanes of signed Q(W-FRAC).FRAC exponents.
// Three elastic register stages: S0 capture, S1 decompose/mantissa,
// S2 shift/saturate. One beat per cycle, 3-cycle latency with out_ready high.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_mode selects the corrected mantissa
//   in_x                : lane k at [k*W +: W]
//   out_valid/out_ready : output handshake
//   out_pow2, out_x     : result per lane and the beat's original x
//   out_sat             : per-lane saturation flag
module pow2_approx_vec
  import softmax_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = Q_W,
  parameter int FRAC  = Q_FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [LANES*W-1:0]   in_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_pow2,
  output logic [LANES*W-1:0]   out_x,
  output logic [LANES-1:0]     out_sat
);

  localparam int STAGES = 2;
  localparam int IW     = W - FRAC;
  localparam int MW     = FRAC + 1;

  logic [STAGES:0]               vld_pipe;
  logic                          ld0, ld1, ld2;

  logic [LANES-1:0][W-1:0]       x_in;
  logic [LANES-1:0][W-1:0]       x0, x1, x2;
  logic                          mode0;
  logic [LANES-1:0][IW-1:0]      i_c, i1;
  logic [LANES-1:0][MW-1:0]      m_c, m1;
  logic [LANES-1:0][W-1:0]       pow2_c, p2;
  logic [LANES-1:0]              sat_c, sat2;

  assign x_in = in_x;

  // A stage may load when empty or when its content leaves this cycle;
  // chaining the readiness backwards lets bubbles collapse.
  assign ld2 = !vld_pipe[2] || out_ready;
  assign ld1 = !vld_pipe[1] || ld2;
  assign ld0 = !vld_pipe[0] || ld1;

  assign in_ready  = !rst && ld0;
  assign out_valid = !rst && vld_pipe[2];
  assign out_pow2  = p2;
  assign out_x     = x2;
  assign out_sat   = sat2;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pow2_lane #(.W(W), .FRAC(FRAC)) u_lane (
      .x       (x0[k]),
      .mode    (mode0),
      .ipart   (i_c[k]),
      .mant    (m_c[k]),
      .ipart_q (i1[k]),
      .mant_q  (m1[k]),
      .pow2    (pow2_c[k]),
      .sat     (sat_c[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      x0       <= '0;
      mode0    <= 1'b0;
      x1       <= '0;
      i1       <= '0;
      m1       <= '0;
      x2       <= '0;
      p2       <= '0;
      sat2     <= '0;
    end else begin
      if (ld0) begin
        vld_pipe[0] <= in_valid;
        if (in_valid) begin
          x0    <= x_in;
          mode0 <= in_mode;
        end
      end
      if (ld1) begin
        vld_pipe[1] <= vld_pipe[0];
        if (vld_pipe[0]) begin
          x1 <= x0;
          i1 <= i_c;
          m1 <= m_c;
        end
      end
      // S2 only reloads on a move, so outputs hold while stalled
      if (ld2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          x2   <= x1;
          p2   <= pow2_c;
          sat2 <= sat_c;
        end
      end
    end
  end

endmodule
